// File: rtl/ddr_package.sv
// ddr_package: shared command encoding, address struct and default DDR4 geometry/timing
package ddr_package;
  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE} command_type;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_QUEUE_DEPTH = 8;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_COL_WIDTH = 10;
  localparam int DEF_ROW_WIDTH = 15;
  localparam int DEF_BA_WIDTH = 2;
  localparam int DEF_BG_WIDTH = 2;
  localparam int DEF_T_RCD = 4;
  localparam int DEF_T_CWL = 5;
  localparam int DEF_T_CL = 6;
  localparam int DEF_T_WR = 6;
  localparam int DEF_T_RTP = 3;
  localparam int DEF_T_RP = 4;
  typedef struct packed {
    logic [DEF_BG_WIDTH-1:0] bg;
    logic [DEF_BA_WIDTH-1:0] ba;
    logic [DEF_ROW_WIDTH-1:0] row;
    logic [DEF_COL_WIDTH-1:0] col;
  } mem_addr_type;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ddr_req_fifo.sv
// ddr_req_fifo: single-clock request FIFO with full/empty flags and same-cycle push/pop
module ddr_req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler: DDR4 ACT/RD/WR/PRE scheduler with write-burst engine.
// Define DDR_AUTO_PRECHARGE_EN to issue CAS with A10 set and skip the explicit PRE.
module ddr_cmd_scheduler
  import ddr_package::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int COL_WIDTH = DEF_COL_WIDTH,
  parameter int ROW_WIDTH = DEF_ROW_WIDTH,
  parameter int BA_WIDTH = DEF_BA_WIDTH,
  parameter int BG_WIDTH = DEF_BG_WIDTH,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_CWL = DEF_T_CWL,
  parameter int T_CL = DEF_T_CL,
  parameter int T_WR = DEF_T_WR,
  parameter int T_RTP = DEF_T_RTP,
  parameter int T_RP = DEF_T_RP
) (
  input  logic                            clock_t,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_rw,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH*BURST_LEN-1:0] req_wdata,
  output command_type                     cmd,
  output logic [BG_WIDTH-1:0]             cmd_bg,
  output logic [BA_WIDTH-1:0]             cmd_ba,
  output logic [ROW_WIDTH-1:0]            cmd_row,
  output logic [COL_WIDTH-1:0]            cmd_col,
  output logic                            cmd_ap,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic                            wr_valid,
  output logic                            rd_window,
  output logic                            busy
);
  localparam int BUS_W = DATA_WIDTH * BURST_LEN;
  localparam int REQ_W = 1 + BG_WIDTH + BA_WIDTH + ROW_WIDTH + COL_WIDTH + BUS_W;
  localparam int T_WDLY = T_CWL + BURST_LEN + T_WR;
  localparam int T_MAX = max_int(max_int(T_RCD, T_WDLY), max_int(T_RTP, T_RP));
  localparam int TW = $clog2(T_MAX + 1);
  localparam int CW = $clog2(T_CWL + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
`ifdef DDR_AUTO_PRECHARGE_EN
  localparam logic AP_EN = 1'b1;
`else
  localparam logic AP_EN = 1'b0;
`endif
  typedef enum logic [2:0] {ST_IDLE, ST_ACT, ST_RCD, ST_CAS, ST_DLY, ST_PRE, ST_RP} state_t;
  state_t state;
  logic [TW-1:0] tmr;
  logic [REQ_W-1:0] head;
  logic full, empty, pop;
  logic h_rw;
  logic [BG_WIDTH-1:0] h_bg, b_bg;
  logic [BA_WIDTH-1:0] h_ba, b_ba;
  logic [ROW_WIDTH-1:0] h_row;
  logic [COL_WIDTH-1:0] h_col;
  logic [BUS_W-1:0] h_data, wbuf;
  logic [CW-1:0] wwait;
  logic [BW-1:0] wcnt;
  logic [T_CL+BURST_LEN-1:0] rsr;
  // addresses are decoded on entry so the FIFO holds ready-to-issue fields
  ddr_req_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(REQ_W)) u_fifo (
    .clk(clock_t),
    .rst(reset),
    .push(req_valid && !full),
    .pop(pop),
    .din({req_rw,
          req_addr[3+COL_WIDTH+BA_WIDTH +: BG_WIDTH],
          req_addr[3+COL_WIDTH +: BA_WIDTH],
          req_addr[3+COL_WIDTH+BA_WIDTH+BG_WIDTH +: ROW_WIDTH],
          req_addr[3 +: COL_WIDTH],
          req_wdata}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign {h_rw, h_bg, h_ba, h_row, h_col, h_data} = head;
  assign req_ready = !full;
  assign pop = (state == ST_ACT || state == ST_RCD) && tmr == '0;
  assign rd_window = |rsr[T_CL +: BURST_LEN];
  assign busy = state != ST_IDLE || !empty || wcnt != '0 || wr_valid || |rsr;
  always_ff @(posedge clock_t or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      tmr <= '0;
      cmd <= NOP;
      cmd_bg <= '1;
      cmd_ba <= '1;
      cmd_row <= '1;
      cmd_col <= '1;
      cmd_ap <= 1'b0;
      b_bg <= '0;
      b_ba <= '0;
    end else begin
      cmd <= NOP;
      cmd_bg <= '1;
      cmd_ba <= '1;
      cmd_row <= '1;
      cmd_col <= '1;
      cmd_ap <= 1'b0;
      case (state)
        ST_IDLE:
          if (!empty) begin
            state <= ST_ACT;
            tmr <= TW'(T_RCD - 1);
            cmd <= ACT;
            cmd_bg <= h_bg;
            cmd_ba <= h_ba;
            cmd_row <= h_row;
            b_bg <= h_bg;
            b_ba <= h_ba;
          end
        ST_ACT, ST_RCD:
          if (tmr == '0) begin
            state <= ST_CAS;
            tmr <= h_rw ? TW'(T_WDLY - 1) : TW'(T_RTP - 1);
            cmd <= h_rw ? WR : RD;
            cmd_bg <= h_bg;
            cmd_ba <= h_ba;
            cmd_col <= h_col;
            cmd_ap <= AP_EN;
          end else begin
            state <= ST_RCD;
            tmr <= tmr - 1'b1;
          end
        ST_CAS, ST_DLY:
          if (tmr == '0) begin
            if (AP_EN) begin
              // the precharge cycle is folded into RP, so RP runs one cycle short
              state <= T_RP > 1 ? ST_RP : ST_IDLE;
              tmr <= TW'(T_RP > 1 ? T_RP - 2 : 0);
            end else begin
              state <= ST_PRE;
              tmr <= TW'(T_RP - 1);
              cmd <= PRE;
              cmd_bg <= b_bg;
              cmd_ba <= b_ba;
            end
          end else begin
            state <= ST_DLY;
            tmr <= tmr - 1'b1;
          end
        default:
          if (tmr == '0) state <= ST_IDLE;
          else begin
            state <= ST_RP;
            tmr <= tmr - 1'b1;
          end
      endcase
    end
  always_ff @(posedge clock_t or posedge reset)
    if (reset) begin
      wbuf <= '0;
      wwait <= '0;
      wcnt <= '0;
      wr_valid <= 1'b0;
      wr_data <= '0;
      rsr <= '0;
    end else begin
      wr_valid <= 1'b0;
      wr_data <= '0;
      rsr <= {rsr[T_CL+BURST_LEN-2:0], pop && !h_rw};
      if (pop && h_rw) begin
        wbuf <= h_data;
        wwait <= CW'(T_CWL - 1);
        wcnt <= BW'(BURST_LEN);
      end else if (wcnt != '0) begin
        if (wwait != '0) wwait <= wwait - 1'b1;
        else begin
          wr_valid <= 1'b1;
          wr_data <= wbuf[DATA_WIDTH-1:0];
          wbuf <= wbuf >> DATA_WIDTH;
          wcnt <= wcnt - 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb_ddr_cmd_scheduler: directed checks of command timing, data windows, FIFO backpressure and reset abort
module tb_ddr_cmd_scheduler;
  import ddr_package::*;
`ifdef DDR_AUTO_PRECHARGE_EN
  localparam int AP = 1;
`else
  localparam int AP = 0;
`endif
  logic clock_t = 0, reset = 0, req_valid = 0, req_rw = 0;
  logic [31:0] req_addr = '0;
  logic [511:0] req_wdata = '0;
  command_type cmd;
  logic [1:0] cmd_bg, cmd_ba;
  logic [14:0] cmd_row;
  logic [9:0] cmd_col;
  logic cmd_ap, req_ready, wr_valid, rd_window, busy;
  logic [63:0] wr_data;
  int checks = 0, errors = 0;

  ddr_cmd_scheduler dut (
    .clock_t(clock_t), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .cmd(cmd),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_ap(cmd_ap), .wr_data(wr_data), .wr_valid(wr_valid), .rd_window(rd_window),
    .busy(busy)
  );

  always #5 clock_t = ~clock_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_t);
    #1;
  endtask

  initial begin
    logic [511:0] wd;
    command_type ec;
    int nrd;
    for (int i = 0; i < 8; i++) wd[i*64 +: 64] = 64'((i + 1) * 17);
    #1 reset = 1;
    #1;
    chk("rst_cmd", cmd, NOP);
    chk("rst_row", cmd_row, 15'h7fff);
    chk("rst_col", cmd_col, 10'h3ff);
    chk("rst_bgba", {cmd_bg, cmd_ba}, 4'hf);
    chk("rst_ap", cmd_ap, 0);
    chk("rst_wr", {wr_valid, wr_data}, 65'h0);
    chk("rst_rdw", rd_window, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    step();
    step();
    reset = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_cmd", cmd, NOP);
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
    end

    // single read, col 8, bank 0
    req_valid = 1; req_rw = 0; req_addr = 32'h40;
    step();
    req_valid = 0;
    for (int k = 1; k <= 22; k++) begin
      step();
      ec = command_type'(k == 1 ? ACT : k == 5 ? RD : (k == 8 && AP == 0) ? PRE : NOP);
      chk("rd_cmd", cmd, ec);
      chk("rd_window", rd_window, k >= 11 && k <= 18);
      chk("rd_wrvalid", wr_valid, 0);
      if (k == 5) chk("rd_col", {cmd_col, cmd_ap}, {10'h008, 1'(AP)});
    end
    chk("rd_idle", busy, 0);

    // single write at 0x0001_2348, then a batch of reads pushed while the write is in DLY
    req_valid = 1; req_rw = 1; req_addr = 32'h0001_2348; req_wdata = wd;
    step();
    req_valid = 0;
    nrd = 0;
    for (int k = 1; k <= 160; k++) begin
      step();
      if (k <= 29) begin
        ec = command_type'((k == 1 || k == 29 - AP) ? ACT : k == 5 ? WR : (k == 24 && AP == 0) ? PRE : NOP);
        chk("wr_cmd", cmd, ec);
      end
      if (k == 1) chk("act_addr", {cmd_bg, cmd_ba, cmd_row}, {2'd2, 2'd1, 15'd0});
      if (k == 5) chk("wr_addr", {cmd_bg, cmd_ba, cmd_col, cmd_ap}, {2'd2, 2'd1, 10'h069, 1'(AP)});
      if (k == 24) chk("pre_bank", {cmd_bg, cmd_ba}, AP ? 4'hf : 4'h9);
      chk("wr_valid", wr_valid, k >= 10 && k <= 17);
      if (k >= 10 && k <= 17) chk("wr_beat", wr_data, 64'((k - 9) * 17));
      if (k == 13) chk("ready_7", req_ready, 1);
      if (k == 14) chk("ready_full", req_ready, 0);
      if (k == 32 - AP) chk("ready_hold", req_ready, 0);
      if (k == 33 - AP) chk("ready_pop", req_ready, 1);
      if (cmd == RD) begin
        nrd++;
        chk("rd_order", cmd_col, 10'(nrd));
      end
      if (k > 5 && cmd == WR) chk("stray_wr", 1, 0);
      if (k >= 6 && k <= 13) begin
        req_valid = 1; req_rw = 0; req_addr = 32'((k - 5) << 3);
      end else if (k >= 14 && k < 34 - AP) begin
        req_valid = 1; req_rw = 0; req_addr = 32'(9 << 3);
      end else req_valid = 0;
    end
    chk("batch_count", nrd, 9);
    chk("batch_idle", busy, 0);

    // reset during the third write beat with a second write still queued
    req_valid = 1; req_rw = 1; req_addr = 32'h0; req_wdata = wd;
    step();
    req_addr = 32'h0000_0100;
    step();
    req_valid = 0;
    for (int k = 2; k <= 12; k++) step();
    chk("beat3", {wr_valid, wr_data}, {1'b1, 64'h33});
    reset = 1;
    #1;
    chk("abort_wrvalid", wr_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_cmd", {cmd, cmd_row}, {NOP, 15'h7fff});
    step();
    reset = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst", {cmd, wr_valid, busy}, {NOP, 2'b00});
    end
    req_valid = 1; req_rw = 0; req_addr = 32'h80;
    step();
    req_valid = 0;
    step();
    chk("post_rst_act", cmd, ACT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
